// File: rtl/vga_axil_slave.sv
// ---------------------------------------------------------------------------
// vga_axil_slave
//   AXI4-Lite register slave for the VGA block. Exposes REG_NUM read/write
//   control words followed by one read-only STATUS word. Accesses are
//   word-addressed (addr[1:0] ignored).
//
//   Word map (index = addr[ADDR_W-1:2]):
//     0 .. REG_NUM-1 : RW registers, mirrored on regs_o
//     REG_NUM        : STATUS (reads status_i, writes -> SLVERR)
//     others         : unmapped (reads 0 / SLVERR, writes -> SLVERR)
//
//   Ports:
//     clk, rst                      single clock, synchronous active-high reset
//     awaddr/awvalid/awready        write-address channel
//     wdata/wstrb/wvalid/wready     write-data channel
//     bresp/bvalid/bready           write-response channel
//     araddr/arvalid/arready        read-address channel
//     rdata/rresp/rvalid/rready     read-data channel
//     regs_o                        RW register i at [i*DATA_W +: DATA_W]
//     status_i                      read-only STATUS word
//
//   Build option:
//     VGA_AXIL_WSTRB_EN  when defined, writes honour wstrb byte lanes;
//                        otherwise every OKAY write replaces the full word.
// ---------------------------------------------------------------------------
module vga_axil_slave #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int REG_NUM = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_W-1:0]         awaddr,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [DATA_W/8-1:0]       wstrb,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
  input  logic [ADDR_W-1:0]         araddr,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [DATA_W-1:0]         rdata,
  output logic [1:0]                rresp,
  output logic                      rvalid,
  input  logic                      rready,
  output logic [REG_NUM*DATA_W-1:0] regs_o,
  input  logic [DATA_W-1:0]         status_i
);

  localparam int IDX_W  = ADDR_W - 2;
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0]       RESP_OKAY   = 2'b00;
  localparam logic [1:0]       RESP_SLVERR = 2'b10;
  localparam logic [IDX_W-1:0] STATUS_IDX  = IDX_W'(REG_NUM);

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  // Register file
  logic [DATA_W-1:0] r_regs [REG_NUM];

  // Write channel state
  w_state_t          r_wstate;
  logic              r_awready;
  logic              r_wready;
  logic              r_aw_got;
  logic              r_w_got;
  logic              r_bvalid;
  logic [1:0]        r_bresp;
  logic [IDX_W-1:0]  r_awidx;
  logic [DATA_W-1:0] r_wdata;

  // Read channel state
  r_state_t          r_rstate;
  logic              r_arready;
  logic              r_rvalid;
  logic [1:0]        r_rresp;
  logic [DATA_W-1:0] r_rdata;

  logic [IDX_W-1:0]  w_ridx;
  logic [DATA_W-1:0] w_rd_word;
  logic [1:0]        w_rd_resp;
  logic              w_wr_ok;
  logic              w_unused_lsb;

  assign w_unused_lsb = ^{awaddr[1:0], araddr[1:0]};

`ifdef VGA_AXIL_WSTRB_EN
  logic [STRB_W-1:0] r_wstrb;

  // Byte-lane merge: only lanes whose strobe is set take the new data.
  function automatic logic [DATA_W-1:0] f_merge(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [STRB_W-1:0] strb
  );
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return res;
  endfunction
`else
  logic w_unused_wstrb;
  assign w_unused_wstrb = ^wstrb;
`endif

  // Only RW indices are writable; STATUS and unmapped words answer SLVERR.
  assign w_wr_ok = (r_awidx < STATUS_IDX);

  // ---- write path: payload capture (no reset, gated by ready) ----
  always_ff @(posedge clk) begin
    if (awvalid && r_awready) r_awidx <= awaddr[ADDR_W-1:2];
    if (wvalid && r_wready) begin
      r_wdata <= wdata;
`ifdef VGA_AXIL_WSTRB_EN
      r_wstrb <= wstrb;
`endif
    end
  end

  // ---- write FSM: accept AW/W independently, commit, then respond ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_aw_got  <= 1'b0;
      r_w_got   <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      for (int i = 0; i < REG_NUM; i++) r_regs[i] <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (r_aw_got && r_w_got) begin
            if (w_wr_ok) begin
              for (int i = 0; i < REG_NUM; i++) begin
                if (r_awidx == IDX_W'(i)) begin
`ifdef VGA_AXIL_WSTRB_EN
                  r_regs[i] <= f_merge(r_regs[i], r_wdata, r_wstrb);
`else
                  r_regs[i] <= r_wdata;
`endif
                end
              end
            end
            r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
            r_bvalid <= 1'b1;
            r_aw_got <= 1'b0;
            r_w_got  <= 1'b0;
            r_wstate <= W_RESP;
          end else begin
            // Each ready stays high until its own beat lands, then drops
            // until the response has been taken.
            if (!r_aw_got) begin
              if (awvalid && r_awready) begin
                r_aw_got  <= 1'b1;
                r_awready <= 1'b0;
              end else begin
                r_awready <= 1'b1;
              end
            end
            if (!r_w_got) begin
              if (wvalid && r_wready) begin
                r_w_got  <= 1'b1;
                r_wready <= 1'b0;
              end else begin
                r_wready <= 1'b1;
              end
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // ---- read path: address decode ----
  assign w_ridx = araddr[ADDR_W-1:2];

  always_comb begin
    w_rd_word = '0;
    w_rd_resp = RESP_SLVERR;
    for (int i = 0; i < REG_NUM; i++) begin
      if (w_ridx == IDX_W'(i)) begin
        w_rd_word = r_regs[i];
        w_rd_resp = RESP_OKAY;
      end
    end
    if (w_ridx == STATUS_IDX) begin
      w_rd_word = status_i;
      w_rd_resp = RESP_OKAY;
    end
  end

  // ---- read FSM: register the word at AR acceptance, hold until taken ----
  // Sampling r_regs here sees the pre-commit value when a write lands on
  // the same edge, so a colliding read returns the old contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (arvalid && r_arready) begin
            r_rdata   <= w_rd_word;
            r_rresp   <= w_rd_resp;
            r_rvalid  <= 1'b1;
            r_arready <= 1'b0;
            r_rstate  <= R_DATA;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (rready) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  // ---- outputs ----
  assign awready = r_awready;
  assign wready  = r_wready;
  assign bvalid  = r_bvalid;
  assign bresp   = r_bresp;
  assign arready = r_arready;
  assign rvalid  = r_rvalid;
  assign rresp   = r_rresp;
  assign rdata   = r_rdata;

  for (genvar g = 0; g < REG_NUM; g++) begin : g_regs_o
    assign regs_o[g*DATA_W +: DATA_W] = r_regs[g];
  end

endmodule

// File: tb/tb_vga_axil_slave.sv
// ---------------------------------------------------------------------------
// tb_vga_axil_slave
//   Directed self-checking bench for vga_axil_slave (default parameters).
//   Inputs are driven on the falling edge, outputs sampled on the falling
//   edge; a small register model tracks the expected contents of regs_o.
// ---------------------------------------------------------------------------
module tb_vga_axil_slave;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int REG_NUM = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst;
  logic [ADDR_W-1:0]         awaddr;
  logic                      awvalid;
  logic                      awready;
  logic [DATA_W-1:0]         wdata;
  logic [DATA_W/8-1:0]       wstrb;
  logic                      wvalid;
  logic                      wready;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;
  logic [ADDR_W-1:0]         araddr;
  logic                      arvalid;
  logic                      arready;
  logic [DATA_W-1:0]         rdata;
  logic [1:0]                rresp;
  logic                      rvalid;
  logic                      rready;
  logic [REG_NUM*DATA_W-1:0] regs_o;
  logic [DATA_W-1:0]         status_i;

  vga_axil_slave #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .REG_NUM(REG_NUM)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .awaddr  (awaddr),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready),
    .regs_o  (regs_o),
    .status_i(status_i)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [DATA_W-1:0] m_regs [REG_NUM];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] m_pack();
    return {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
  endfunction

  // Called on a falling edge; returns on a falling edge.
  task automatic axi_write(input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp);
    bit aw_done, w_done, aa, ww;
    int t;
    aw_done = 0; w_done = 0; t = 0; resp = 2'b11;
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
    while (!(aw_done && w_done) && t < 20) begin
      aa = awvalid && awready;
      ww = wvalid && wready;
      @(negedge clk);
      t++;
      if (aa) begin aw_done = 1; awvalid = 1'b0; end
      if (ww) begin w_done = 1; wvalid = 1'b0; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_done && w_done)) chk("wr_accept_timeout", 0, 1);
    bready = 1'b1; t = 0;
    while (!bvalid && t < 20) begin @(negedge clk); t++; end
    if (bvalid) begin
      resp = bresp;
      @(negedge clk);
    end else begin
      chk("wr_b_timeout", 0, 1);
    end
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit ar_done, aa;
    int t;
    ar_done = 0; t = 0; d = '0; resp = 2'b11;
    araddr = a; arvalid = 1'b1;
    while (!ar_done && t < 20) begin
      aa = arvalid && arready;
      @(negedge clk);
      t++;
      if (aa) begin ar_done = 1; arvalid = 1'b0; end
    end
    arvalid = 1'b0;
    if (!ar_done) chk("rd_accept_timeout", 0, 1);
    rready = 1'b1; t = 0;
    while (!rvalid && t < 20) begin @(negedge clk); t++; end
    if (rvalid) begin
      d = rdata; resp = rresp;
      @(negedge clk);
    end else begin
      chk("rd_r_timeout", 0, 1);
    end
    rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] d;

    rst = 1'b1; awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0; status_i = 32'hA5A5_0001;
    for (int i = 0; i < REG_NUM; i++) m_regs[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_regs", regs_o, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_awready", awready, 1);
    chk("post_rst_wready", wready, 1);
    chk("post_rst_arready", arready, 1);

    // AW and W together, then read back
    axi_write(8'h04, 32'hDEADBEEF, 4'hF, resp);
    m_regs[1] = 32'hDEADBEEF;
    chk("wr04_bresp", resp, 2'b00);
    chk("wr04_regs_o", regs_o[63:32], 32'hDEADBEEF);
    axi_read(8'h04, d, resp);
    chk("rd04_data", d, 32'hDEADBEEF);
    chk("rd04_resp", resp, 2'b00);

    // W two cycles ahead of AW, B held off for 3 cycles
    wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    chk("wfirst_wready_low", wready, 0);
    chk("wfirst_awready_high", awready, 1);
    @(negedge clk);
    awaddr = 8'h00; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    chk("wfirst_no_b_yet", bvalid, 0);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("wfirst_bvalid_hold", bvalid, 1);
      chk("wfirst_bresp_hold", bresp, 2'b00);
      chk("wfirst_awready_resp", awready, 0);
      @(negedge clk);
    end
    m_regs[0] = 32'h12345678;
    chk("wfirst_reg0", regs_o, m_pack());
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("wfirst_b_done", bvalid, 0);
    repeat (2) @(negedge clk);
    chk("wfirst_no_second_b", bvalid, 0);
    chk("wfirst_regs_stable", regs_o, m_pack());

    // STATUS write, unmapped accesses, STATUS read, ignored address LSBs
    axi_write(8'h10, 32'h00005555, 4'hF, resp);
    chk("wr_status_bresp", resp, 2'b10);
    chk("wr_status_regs", regs_o, m_pack());
    axi_write(8'h23, 32'h77777777, 4'hF, resp);
    chk("wr_unmapped_bresp", resp, 2'b10);
    chk("wr_unmapped_regs", regs_o, m_pack());
    axi_read(8'h20, d, resp);
    chk("rd_unmapped_data", d, 0);
    chk("rd_unmapped_resp", resp, 2'b10);
    axi_read(8'h12, d, resp);
    chk("rd_status_data", d, 32'hA5A5_0001);
    chk("rd_status_resp", resp, 2'b00);
    axi_read(8'h07, d, resp);
    chk("rd_lsb_ignored", d, 32'hDEADBEEF);

    // Byte strobes
    axi_write(8'h04, 32'hFFFFFFFF, 4'hF, resp);
    axi_write(8'h04, 32'h000000AA, 4'b0001, resp);
`ifdef VGA_AXIL_WSTRB_EN
    m_regs[1] = 32'hFFFFFFAA;
`else
    m_regs[1] = 32'h000000AA;
`endif
    chk("strb_bresp", resp, 2'b00);
    chk("strb_reg1", regs_o[63:32], m_regs[1]);
    axi_write(8'h04, 32'h00000012, 4'b0000, resp);
`ifndef VGA_AXIL_WSTRB_EN
    m_regs[1] = 32'h00000012;
`endif
    chk("strb0_bresp", resp, 2'b00);
    chk("strb0_reg1", regs_o, m_pack());

    // Read colliding with a write commit to the same register
    axi_write(8'h0C, 32'h00000011, 4'hF, resp);
    m_regs[3] = 32'h11;
    awaddr = 8'h0C; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 8'h0C; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    m_regs[3] = 32'h55;
    chk("coll_rvalid", rvalid, 1);
    chk("coll_rdata_old", rdata, 32'h11);
    chk("coll_rresp", rresp, 2'b00);
    chk("coll_bvalid", bvalid, 1);
    chk("coll_reg3_new", regs_o, m_pack());
    @(negedge clk);
    chk("coll_rvalid_hold", rvalid, 1);
    chk("coll_rdata_hold", rdata, 32'h11);
    rready = 1'b1; bready = 1'b1;
    @(negedge clk);
    rready = 1'b0; bready = 1'b0;
    chk("b2b_rvalid_low", rvalid, 0);
    chk("b2b_arready", arready, 1);
    chk("b2b_awready", awready, 1);
    chk("b2b_wready", wready, 1);
    axi_read(8'h0C, d, resp);
    chk("coll_reread", d, 32'h55);

    // Reset between AW and W aborts the write
    awaddr = 8'h08; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < REG_NUM; i++) m_regs[i] = '0;
    chk("abort_awready_rst", awready, 0);
    chk("abort_regs_clr", regs_o, 0);
    @(negedge clk);
    wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_no_bvalid", bvalid, 0);
    chk("abort_no_update", regs_o, 0);
    for (int i = 0; i < REG_NUM; i++) begin
      axi_read(8'(i * 4), d, resp);
      chk("abort_readback", d, 0);
    end

    // Pending rvalid drops on reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    araddr = 8'h00; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    chk("rst_mid_rvalid_pre", rvalid, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_rvalid_drop", rvalid, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
